matrix_datapath: RTL and testbench
==================================

Name:
matrix_datapath

Overview:
- Execute stage of the matrix processor: instruction decoder, matrix register file and matrix ALU in one block.
- Consumes one 32-bit instruction per cycle from the fetch stage.
- Reports jump requests and halt back to the PC/controller logic.
- Each register holds a WIDTH x WIDTH matrix of 32-bit words, WIDTH = 2**WIDTH_BIT.

Parameters:
- WIDTH_BIT, 1, log2 of matrix dimension (WIDTH = 2).
- INDEX_BIT, 3, register index width (8 matrix registers).
- INSTR_BIT, 8, instruction-address width (jump target width).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- enable  input  1  executes the current instruction; when low, no register write occurs.
- instruction  input  32  current instruction.
- pc_src  output  1  current instruction is JMP.
- jump_addr  output  INSTR_BIT  jump target, instruction[INSTR_BIT-1:0].
- done  output  1  current instruction is HALT.
- dbg_index  input  INDEX_BIT  debug read select.
- dbg_data  output  WIDTH*WIDTH*32  matrix at dbg_index (combinational).

Behaviour:
- One clock; reset is asynchronous and active-high.
- While RST is high, all registers hold 0.

Matrix bus format:
- Element (i,j) is at bits [32*(i*WIDTH+j) +: 32].
- i = row, j = column.

Instruction fields:
- op = [31:29].
- d = [28 -: INDEX_BIT].
- a = next INDEX_BIT bits below d.
- b = next INDEX_BIT bits below a.
- imm = [28-INDEX_BIT:0], 29-INDEX_BIT bits.

Opcodes:
- 000 LDE: R[d](row,col) = zero-extended instr[15:0]; other elements of R[d] are unchanged. col = instr[16 +: WIDTH_BIT], row = instr[16+WIDTH_BIT +: WIDTH_BIT]. Requires 16+2*WIDTH_BIT <= 29-INDEX_BIT.
- 001 ADD: R[d] = R[a] + R[b], elementwise.
- 010 SUB: R[d] = R[a] - R[b], elementwise.
- 011 MUL: R[d] = R[a] x R[b], true matrix product.
- 100 TRN: R[d] = transpose(R[a]).
- 101 LDI: every element of R[d] = zero-extended imm.
- 110 JMP: pc_src = 1; no register write.
- 111 HALT: done = 1; no register write.

Arithmetic:
- All results are 32-bit modulo 2^32, unsigned wrap.
- MUL: products and sums are truncated to 32 bits.
- No flags.

Timing and outputs:
- Register reads, ALU, pc_src, jump_addr and done are combinational.
- The register write happens on the rising CLK edge when enable = 1 and op is 000–101.
- Result is visible on dbg_data after that edge.
- pc_src, jump_addr and done are driven whenever the opcode matches, regardless of enable; the controller qualifies them.

Boundary conditions:
- d equal to a or b: operands are the pre-edge values, so the result lands in the same cycle.
- Read during write on the same index returns the old value until the edge.
- RST asserted mid-cycle clears all registers immediately; a write on that edge is discarded.
- After RST falls, the first write is accepted on the next rising edge.
- enable = 0 with any opcode: register file unchanged.

Optional Feature:
- Macro R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to the zero matrix.
  - Writes with d = 0 are discarded.
  - Reads and dbg_data of index 0 return 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: load R1 with LDI 7, pulse RST between clock edges -> dbg_data for every index = 0 with no clock edge required.
- LDI/ADD/SUB: LDI R1,5; LDI R2,3; ADD R3=R1+R2; SUB R4=R2-R1 -> R3 all elements 8, R4 all elements 0xFFFFFFFE.
- LDE/TRN/MUL: LDE R1 to [[1,2],[3,4]]; TRN R2=R1 -> [[1,3],[2,4]]; MUL R3=R1xR1 -> [[7,10],[15,22]].
- Overflow/aliasing: LDI R1 = 0x1FFFFFF, then MUL R1=R1xR1 repeated -> each element = 2*x*x mod 2^32 computed from the pre-edge value.
- Control/enable:
  - JMP with instruction[7:0] = 0x2A -> pc_src = 1, jump_addr = 0x2A, no register change.
  - HALT -> done = 1.
  - ADD with enable = 0 -> destination unchanged.
- R0_ZERO_EN: LDI R0,9 -> with macro, dbg_data[0] = 0; without macro, dbg_data[0] = all elements 9.

Source files
------------

// File: rtl/matrix_datapath.sv
// Execute stage of the matrix processor: decoder, matrix register file and matrix ALU.
// Optional macro R0_ZERO_EN hardwires register 0 to the zero matrix.
module matrix_datapath #(
  parameter int WIDTH_BIT = 1,
  parameter int INDEX_BIT = 3,
  parameter int INSTR_BIT = 8
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              enable,
  input  logic [31:0]                       instruction,
  output logic                              pc_src,
  output logic [INSTR_BIT-1:0]              jump_addr,
  output logic                              done,
  input  logic [INDEX_BIT-1:0]              dbg_index,
  output logic [(32 << (2*WIDTH_BIT))-1:0]  dbg_data
);

  localparam int WIDTH = 1 << WIDTH_BIT;
  localparam int ELEMS = WIDTH * WIDTH;
  localparam int NREG  = 1 << INDEX_BIT;
  localparam int IMM_W = 29 - INDEX_BIT;

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Element (i,j) sits at packed index i*WIDTH+j, i.e. bits [32*(i*WIDTH+j) +: 32].
  typedef logic [ELEMS-1:0][31:0] mat_t;

  typedef enum logic [2:0] {
    OP_LDE  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MUL  = 3'b011,
    OP_TRN  = 3'b100,
    OP_LDI  = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  op_e                  op;
  logic [INDEX_BIT-1:0] d_idx, a_idx, b_idx;
  logic [IMM_W-1:0]     imm;
  logic [WIDTH_BIT-1:0] lde_row, lde_col;

  assign op      = op_e'(instruction[31:29]);
  assign d_idx   = instruction[28 -: INDEX_BIT];
  assign a_idx   = instruction[28-INDEX_BIT -: INDEX_BIT];
  assign b_idx   = instruction[28-2*INDEX_BIT -: INDEX_BIT];
  assign imm     = instruction[IMM_W-1:0];
  assign lde_col = instruction[16 +: WIDTH_BIT];
  assign lde_row = instruction[16+WIDTH_BIT +: WIDTH_BIT];

  mat_t regs [NREG];
  mat_t mat_a, mat_b, mat_d, result;
  logic wr_req, wr_en;
  logic [31:0] mul_acc;

  // Reads are combinational, so an aliased destination sees the pre-edge operands.
  assign mat_a    = (R0_ZERO && a_idx == '0)     ? '0 : regs[a_idx];
  assign mat_b    = (R0_ZERO && b_idx == '0)     ? '0 : regs[b_idx];
  assign mat_d    = (R0_ZERO && d_idx == '0)     ? '0 : regs[d_idx];
  assign dbg_data = (R0_ZERO && dbg_index == '0) ? '0 : regs[dbg_index];

  always_comb begin
    result  = mat_d;
    wr_req  = 1'b0;
    mul_acc = '0;
    case (op)
      OP_LDE: begin
        result[{lde_row, lde_col}] = 32'(instruction[15:0]);
        wr_req = 1'b1;
      end
      OP_ADD: begin
        for (int e = 0; e < ELEMS; e++) result[e] = mat_a[e] + mat_b[e];
        wr_req = 1'b1;
      end
      OP_SUB: begin
        for (int e = 0; e < ELEMS; e++) result[e] = mat_a[e] - mat_b[e];
        wr_req = 1'b1;
      end
      OP_MUL: begin
        for (int i = 0; i < WIDTH; i++) begin
          for (int j = 0; j < WIDTH; j++) begin
            mul_acc = '0;
            for (int k = 0; k < WIDTH; k++)
              mul_acc = mul_acc + mat_a[i*WIDTH+k] * mat_b[k*WIDTH+j];
            result[i*WIDTH+j] = mul_acc;
          end
        end
        wr_req = 1'b1;
      end
      OP_TRN: begin
        for (int i = 0; i < WIDTH; i++)
          for (int j = 0; j < WIDTH; j++)
            result[i*WIDTH+j] = mat_a[j*WIDTH+i];
        wr_req = 1'b1;
      end
      OP_LDI: begin
        for (int e = 0; e < ELEMS; e++) result[e] = {{(32-IMM_W){1'b0}}, imm};
        wr_req = 1'b1;
      end
      default: wr_req = 1'b0;
    endcase
  end

  assign wr_en = enable && wr_req && !(R0_ZERO && d_idx == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[d_idx] <= result;
    end
  end

  // Control outputs follow the opcode alone; the PC controller qualifies them with enable.
  assign pc_src    = (op == OP_JMP);
  assign done      = (op == OP_HALT);
  assign jump_addr = instruction[INSTR_BIT-1:0];

endmodule

// File: tb/tb_matrix_datapath.sv
// Self-checking bench for matrix_datapath: directed scenarios plus randomized
// instruction streams checked against a behavioural matrix model.
module tb_matrix_datapath;

  localparam int NREG = 8;

`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         enable;
  logic [31:0]  instruction;
  logic         pc_src;
  logic [7:0]   jump_addr;
  logic         done;
  logic [2:0]   dbg_index;
  logic [127:0] dbg_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mdl [NREG][4];
  logic [31:0] cur_instr;
  logic        cur_en;

  always #5 CLK = ~CLK;

  matrix_datapath #(.WIDTH_BIT(1), .INDEX_BIT(3), .INSTR_BIT(8)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .instruction(instruction),
    .pc_src(pc_src), .jump_addr(jump_addr), .done(done),
    .dbg_index(dbg_index), .dbg_data(dbg_data)
  );

  function automatic logic [31:0] mk_r(input logic [2:0] op, input int d, input int a, input int b);
    return {op, 3'(d), 3'(a), 3'(b), 20'h0};
  endfunction

  function automatic logic [31:0] mk_ldi(input int d, input logic [25:0] imm);
    return {3'b101, 3'(d), imm};
  endfunction

  function automatic logic [31:0] mk_lde(input int d, input bit row, input bit col, input logic [15:0] v);
    return {3'b000, 3'(d), 8'h00, row, col, v};
  endfunction

  function automatic logic [127:0] exp_mat(input int idx);
    logic [127:0] v;
    for (int e = 0; e < 4; e++) v[32*e +: 32] = (R0Z && idx == 0) ? 32'h0 : mdl[idx][e];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) for (int e = 0; e < 4; e++) mdl[r][e] = 32'h0;
  endtask

  // Matrix semantics straight from the instruction set description.
  task automatic model_update();
    logic [2:0]  op;
    int          d, a, b;
    logic [31:0] ma [4];
    logic [31:0] mb [4];
    logic [31:0] s;
    op = cur_instr[31:29];
    d  = int'(cur_instr[28:26]);
    a  = int'(cur_instr[25:23]);
    b  = int'(cur_instr[22:20]);
    if (!cur_en || op > 3'd5 || (R0Z && d == 0)) return;
    for (int e = 0; e < 4; e++) begin
      ma[e] = mdl[a][e];
      mb[e] = mdl[b][e];
    end
    case (op)
      3'd0: mdl[d][{cur_instr[17], cur_instr[16]}] = {16'h0, cur_instr[15:0]};
      3'd1: for (int e = 0; e < 4; e++) mdl[d][e] = ma[e] + mb[e];
      3'd2: for (int e = 0; e < 4; e++) mdl[d][e] = ma[e] - mb[e];
      3'd3: for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
        s = 32'h0;
        for (int k = 0; k < 2; k++) s = s + ma[r*2+k] * mb[k*2+c];
        mdl[d][r*2+c] = s;
      end
      3'd4: for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) mdl[d][r*2+c] = ma[c*2+r];
      default: for (int e = 0; e < 4; e++) mdl[d][e] = {6'h0, cur_instr[25:0]};
    endcase
  endtask

  task automatic put(input logic [31:0] instr, input logic en);
    @(negedge CLK);
    instruction = instr;
    enable      = en;
    cur_instr   = instr;
    cur_en      = en;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (!RST) model_update();
    enable = 1'b0;
  endtask

  task automatic exec(input logic [31:0] instr, input logic en);
    put(instr, en);
    step();
  endtask

  task automatic peek(input int idx, output logic [127:0] v);
    dbg_index = 3'(idx);
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [127:0] v;
    for (int r = 0; r < NREG; r++) begin
      peek(r, v);
      n_cmp++;
      if (v !== 128'h0) begin n_fail++; $display("FAIL reset_init R%0d got %h exp 0", r, v); end
    end
    @(negedge CLK);
    RST = 1'b0;
    exec(mk_ldi(1, 26'd7), 1'b1);
    peek(1, v);
    n_cmp++;
    if (v !== {4{32'd7}}) begin n_fail++; $display("FAIL reset_ldi7 got %h exp %h", v, {4{32'd7}}); end
    #2;
    RST = 1'b1;
    model_clear();
    for (int r = 0; r < NREG; r++) begin
      peek(r, v);
      n_cmp++;
      if (v !== 128'h0) begin n_fail++; $display("FAIL reset_async R%0d got %h exp 0", r, v); end
    end
    exec(mk_ldi(2, 26'd5), 1'b1);
    peek(2, v);
    n_cmp++;
    if (v !== 128'h0) begin n_fail++; $display("FAIL reset_discard got %h exp 0", v); end
    #2;
    RST = 1'b0;
    exec(mk_ldi(2, 26'd5), 1'b1);
    peek(2, v);
    n_cmp++;
    if (v !== {4{32'd5}}) begin n_fail++; $display("FAIL reset_first_write got %h exp %h", v, {4{32'd5}}); end
  endtask

  task automatic test_ldi_add_sub();
    logic [127:0] v;
    exec(mk_ldi(1, 26'd5), 1'b1);
    exec(mk_ldi(2, 26'd3), 1'b1);
    exec(mk_r(3'b001, 3, 1, 2), 1'b1);
    exec(mk_r(3'b010, 4, 2, 1), 1'b1);
    peek(3, v);
    n_cmp++;
    if (v !== {4{32'd8}}) begin n_fail++; $display("FAIL add got %h exp %h", v, {4{32'd8}}); end
    peek(4, v);
    n_cmp++;
    if (v !== {4{32'hFFFFFFFE}}) begin n_fail++; $display("FAIL sub got %h exp %h", v, {4{32'hFFFFFFFE}}); end
  endtask

  task automatic test_lde_trn_mul();
    logic [127:0] v;
    exec(mk_lde(1, 1'b0, 1'b0, 16'd1), 1'b1);
    peek(1, v);
    n_cmp++;
    if (v !== exp_mat(1)) begin n_fail++; $display("FAIL lde_partial got %h exp %h", v, exp_mat(1)); end
    exec(mk_lde(1, 1'b0, 1'b1, 16'd2), 1'b1);
    exec(mk_lde(1, 1'b1, 1'b0, 16'd3), 1'b1);
    exec(mk_lde(1, 1'b1, 1'b1, 16'd4), 1'b1);
    peek(1, v);
    n_cmp++;
    if (v !== {32'd4, 32'd3, 32'd2, 32'd1}) begin n_fail++; $display("FAIL lde got %h exp [[1,2],[3,4]]", v); end
    exec(mk_r(3'b100, 2, 1, 0), 1'b1);
    peek(2, v);
    n_cmp++;
    if (v !== {32'd4, 32'd2, 32'd3, 32'd1}) begin n_fail++; $display("FAIL trn got %h exp [[1,3],[2,4]]", v); end
    exec(mk_r(3'b011, 3, 1, 1), 1'b1);
    peek(3, v);
    n_cmp++;
    if (v !== {32'd22, 32'd15, 32'd10, 32'd7}) begin n_fail++; $display("FAIL mul got %h exp [[7,10],[15,22]]", v); end
  endtask

  task automatic test_overflow_alias();
    logic [127:0]    v;
    longint unsigned xl;
    logic [31:0]     x2;
    exec(mk_ldi(1, 26'h1FFFFFF), 1'b1);
    for (int n = 0; n < 3; n++) begin
      xl = longint'(mdl[1][0]);
      x2 = 32'(2 * xl * xl);
      exec(mk_r(3'b011, 1, 1, 1), 1'b1);
      peek(1, v);
      n_cmp++;
      if (v !== {4{x2}}) begin n_fail++; $display("FAIL mul_alias iter%0d got %h exp %h", n, v, {4{x2}}); end
    end
  endtask

  task automatic test_control_enable();
    logic [127:0] v;
    logic [31:0]  jmp;
    jmp = {3'b110, 21'($urandom), 8'h2A};
    put(jmp, 1'b1);
    n_cmp++;
    if (pc_src !== 1'b1 || jump_addr !== 8'h2A || done !== 1'b0) begin
      n_fail++; $display("FAIL jmp got pc_src=%b addr=%h done=%b exp 1/2a/0", pc_src, jump_addr, done);
    end
    step();
    for (int r = 0; r < NREG; r++) begin
      peek(r, v);
      n_cmp++;
      if (v !== exp_mat(r)) begin n_fail++; $display("FAIL jmp_nowrite R%0d got %h exp %h", r, v, exp_mat(r)); end
    end
    put({3'b111, 29'($urandom)}, 1'b1);
    n_cmp++;
    if (done !== 1'b1 || pc_src !== 1'b0) begin n_fail++; $display("FAIL halt got done=%b pc_src=%b exp 1/0", done, pc_src); end
    step();
    put(jmp, 1'b0);
    n_cmp++;
    if (pc_src !== 1'b1) begin n_fail++; $display("FAIL jmp_disabled got pc_src=%b exp 1", pc_src); end
    step();
    exec(mk_ldi(5, 26'h123), 1'b1);
    exec(mk_r(3'b001, 5, 1, 2), 1'b0);
    peek(5, v);
    n_cmp++;
    if (v !== {4{32'h123}}) begin n_fail++; $display("FAIL enable_low got %h exp %h", v, {4{32'h123}}); end
  endtask

  task automatic test_r0();
    logic [127:0] v;
    exec(mk_ldi(0, 26'd9), 1'b1);
    peek(0, v);
    n_cmp++;
    if (v !== (R0Z ? 128'h0 : {4{32'd9}})) begin n_fail++; $display("FAIL r0 got %h exp %h", v, R0Z ? 128'h0 : {4{32'd9}}); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v;
    exec(mk_ldi(6, 26'd1), 1'b1);
    for (int n = 0; n < 5; n++) exec(mk_r(3'b001, 6, 6, 6), 1'b1);
    peek(6, v);
    n_cmp++;
    if (v !== {4{32'd32}}) begin n_fail++; $display("FAIL b2b_double got %h exp %h", v, {4{32'd32}}); end
  endtask

  task automatic test_random();
    logic [127:0] v;
    logic [31:0]  instr;
    logic         en;
    int           d, r;
    for (int n = 0; n < 80; n++) begin
      instr        = $urandom;
      instr[31:29] = 3'($urandom_range(0, 7));
      en           = ($urandom_range(0, 3) != 0);
      d            = int'(instr[28:26]);
      put(instr, en);
      n_cmp++;
      if (pc_src !== (instr[31:29] == 3'b110) || done !== (instr[31:29] == 3'b111) || jump_addr !== instr[7:0]) begin
        n_fail++; $display("FAIL rand_ctrl #%0d instr=%h got pc_src=%b done=%b addr=%h", n, instr, pc_src, done, jump_addr);
      end
      step();
      peek(d, v);
      n_cmp++;
      if (v !== exp_mat(d)) begin n_fail++; $display("FAIL rand_dest #%0d instr=%h R%0d got %h exp %h", n, instr, d, v, exp_mat(d)); end
      r = $urandom_range(0, NREG-1);
      peek(r, v);
      n_cmp++;
      if (v !== exp_mat(r)) begin n_fail++; $display("FAIL rand_peek #%0d R%0d got %h exp %h", n, r, v, exp_mat(r)); end
    end
    for (int k = 0; k < NREG; k++) begin
      peek(k, v);
      n_cmp++;
      if (v !== exp_mat(k)) begin n_fail++; $display("FAIL rand_final R%0d got %h exp %h", k, v, exp_mat(k)); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b1;
    enable      = 1'b0;
    instruction = 32'h0;
    dbg_index   = 3'd0;
    cur_instr   = 32'h0;
    cur_en      = 1'b0;
    model_clear();
    #1;
    test_reset();
    test_ldi_add_sub();
    test_lde_trn_mul();
    test_overflow_alias();
    test_control_enable();
    test_r0();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
